// File: rtl/pixel_stacker.sv
// Packs a 16-bit pixel stream into 128-bit AXI-Stream words (8 pixels per word).
// TLAST marks the last word of each frame. The camera side cannot be stalled,
// so a word that cannot be accepted is dropped and flagged, and the block
// resynchronises on the next frame start.
module pixel_stacker #(
    parameter int unsigned FRAME_WORDS = 115200
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         pixel_valid_in,
    input  logic [15:0]  pixel_data_in,
    input  logic         frame_start_in,
    output logic [127:0] stacked_axis_data,
    output logic         stacked_axis_tlast,
    output logic         stacked_axis_valid,
    input  logic         stacked_axis_ready,
    output logic         overflow_out,
    output logic         sync_error_out
);

    localparam int unsigned PIX_W      = 16;
    localparam int unsigned LANES      = 8;
    localparam int unsigned LANE_W     = 3;
    localparam int unsigned WORD_CNT_W = 17;
    localparam int unsigned WORD_W     = PIX_W * LANES;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        STACK     = 1'b1
    } state_e;

    state_e                             state_q, state_d;
    logic [LANE_W-1:0]                  lane_q, lane_d;
    logic [WORD_CNT_W-1:0]              word_q, word_d;
    logic [LANES-2:0][PIX_W-1:0]        acc_q, acc_d;
    logic [WORD_W-1:0]                  data_q, data_d;
    logic                               tlast_q, tlast_d;
    logic                               valid_q, valid_d;
    logic                               ovf_q, ovf_d;
    logic                               sync_err_q, sync_err_d;

    logic start_px;
    logic handshake;
    logic last_word;
    logic at_frame_origin;

    assign start_px        = pixel_valid_in && frame_start_in;
    assign handshake       = valid_q && stacked_axis_ready;
    assign last_word       = (word_q == WORD_CNT_W'(FRAME_WORDS - 1));
    assign at_frame_origin = (lane_q == '0) && (word_q == '0);

    // Next-state: frame sync, lane/word counting, output register load/drop.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        word_d     = word_q;
        acc_d      = acc_q;
        data_d     = data_q;
        tlast_d    = tlast_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        sync_err_d = sync_err_q;

        // A transfer empties the output register unless a new word replaces it below.
        if (handshake) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            WAIT_SYNC: begin
                if (start_px) begin
                    acc_d[0] = pixel_data_in;
                    lane_d   = LANE_W'(1);
                    word_d   = '0;
                    state_d  = STACK;
                end
            end

            STACK: begin
                if (start_px) begin
                    // A frame start anywhere but the frame origin truncates the frame.
                    if (!at_frame_origin) begin
                        sync_err_d = 1'b1;
                    end
                    acc_d[0] = pixel_data_in;
                    lane_d   = LANE_W'(1);
                    word_d   = '0;
                end else if (pixel_valid_in) begin
                    if (lane_q == LANE_W'(LANES - 1)) begin
                        if (!valid_q || handshake) begin
                            data_d  = {pixel_data_in, acc_q};
                            tlast_d = last_word;
                            valid_d = 1'b1;
                            word_d  = last_word ? '0 : word_q + WORD_CNT_W'(1);
                            lane_d  = '0;
                        end else begin
                            // Held word stays; drop this one and realign on next frame.
                            ovf_d   = 1'b1;
                            lane_d  = '0;
                            word_d  = '0;
                            state_d = WAIT_SYNC;
                        end
                    end else begin
                        for (int i = 0; i < int'(LANES - 1); i++) begin
                            if (lane_q == LANE_W'(i)) begin
                                acc_d[i] = pixel_data_in;
                            end
                        end
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end

            default: begin
                state_d = WAIT_SYNC;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= WAIT_SYNC;
            lane_q     <= '0;
            word_q     <= '0;
            acc_q      <= '0;
            data_q     <= '0;
            tlast_q    <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            acc_q      <= acc_d;
            data_q     <= data_d;
            tlast_q    <= tlast_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign stacked_axis_data  = data_q;
    assign stacked_axis_tlast = tlast_q;
    assign stacked_axis_valid = valid_q;
    assign overflow_out       = ovf_q;
    assign sync_error_out     = sync_err_q;

endmodule

// File: tb/tb_pixel_stacker.sv
// Directed bench for pixel_stacker, using a 4-word frame to keep runs short.
module tb_pixel_stacker;

    localparam int unsigned FW = 4;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         pixel_valid_in;
    logic [15:0]  pixel_data_in;
    logic         frame_start_in;
    logic [127:0] stacked_axis_data;
    logic         stacked_axis_tlast;
    logic         stacked_axis_valid;
    logic         stacked_axis_ready;
    logic         overflow_out;
    logic         sync_error_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] got_data[$];
    logic         got_last[$];

    pixel_stacker #(.FRAME_WORDS(FW)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .pixel_valid_in     (pixel_valid_in),
        .pixel_data_in      (pixel_data_in),
        .frame_start_in     (frame_start_in),
        .stacked_axis_data  (stacked_axis_data),
        .stacked_axis_tlast (stacked_axis_tlast),
        .stacked_axis_valid (stacked_axis_valid),
        .stacked_axis_ready (stacked_axis_ready),
        .overflow_out       (overflow_out),
        .sync_error_out     (sync_error_out)
    );

    always #5 clk_in = ~clk_in;

    // Record every word transferred on the next rising edge.
    always @(negedge clk_in) begin
        if (!rst_in && stacked_axis_valid && stacked_axis_ready) begin
            got_data.push_back(stacked_axis_data);
            got_last.push_back(stacked_axis_tlast);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mk(input logic [15:0] b);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            w[16*k +: 16] = b + 16'(k);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_px(input logic v, input logic [15:0] d, input logic fs);
        pixel_valid_in = v;
        pixel_data_in  = d;
        frame_start_in = fs;
        tick();
    endtask

    task automatic idle(input int n);
        pixel_valid_in = 1'b0;
        frame_start_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic reset_dut();
        rst_in             = 1'b1;
        pixel_valid_in     = 1'b0;
        pixel_data_in      = '0;
        frame_start_in     = 1'b0;
        stacked_axis_ready = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        got_data.delete();
        got_last.delete();
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (stacked_axis_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0", stacked_axis_valid);
        end
        n_checks++;
        if (stacked_axis_data !== 128'h0) begin
            n_errors++; $display("FAIL reset_data: got %h want 0", stacked_axis_data);
        end
        n_checks++;
        if (stacked_axis_tlast !== 1'b0) begin
            n_errors++; $display("FAIL reset_tlast: got %b want 0", stacked_axis_tlast);
        end
        n_checks++;
        if ({overflow_out, sync_error_out} !== 2'b00) begin
            n_errors++; $display("FAIL reset_flags: got %b want 00", {overflow_out, sync_error_out});
        end
    endtask

    task automatic test_frame();
        reset_dut();
        for (int p = 0; p < int'(FW * 8); p++) begin
            send_px(1'b1, 16'(p), p == 0);
            if (p == 6) begin
                n_checks++;
                if (stacked_axis_valid !== 1'b0) begin
                    n_errors++; $display("FAIL frame_early_valid: got %b want 0", stacked_axis_valid);
                end
            end
            if (p == 7) begin
                n_checks++;
                if (stacked_axis_valid !== 1'b1) begin
                    n_errors++; $display("FAIL frame_latency: got %b want 1", stacked_axis_valid);
                end
                n_checks++;
                if (stacked_axis_data !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin
                    n_errors++; $display("FAIL frame_word0: got %h want 00070006000500040003000200010000", stacked_axis_data);
                end
            end
        end
        idle(4);
        n_checks++;
        if (got_data.size() != int'(FW)) begin
            n_errors++; $display("FAIL frame_count: got %0d want %0d", got_data.size(), FW);
        end else begin
            for (int k = 0; k < int'(FW); k++) begin
                n_checks++;
                if (got_data[k] !== mk(16'(8 * k)) || got_last[k] !== (k == int'(FW) - 1)) begin
                    n_errors++; $display("FAIL frame_word%0d: got %h/%b want %h/%b", k, got_data[k], got_last[k], mk(16'(8 * k)), k == int'(FW) - 1);
                end
            end
        end
        n_checks++;
        if ({overflow_out, sync_error_out} !== 2'b00) begin
            n_errors++; $display("FAIL frame_flags: got %b want 00", {overflow_out, sync_error_out});
        end
    endtask

    task automatic test_no_sync();
        reset_dut();
        for (int p = 0; p < 10; p++) send_px(1'b1, 16'(500 + p), 1'b0);
        idle(3);
        n_checks++;
        if (got_data.size() != 0 || stacked_axis_valid !== 1'b0) begin
            n_errors++; $display("FAIL nosync_output: got %0d words valid %b want 0 words valid 0", got_data.size(), stacked_axis_valid);
        end
        send_px(1'b1, 16'hABCD, 1'b1);
        for (int p = 1; p < 8; p++) send_px(1'b1, 16'(p), 1'b0);
        idle(3);
        n_checks++;
        if (got_data.size() != 1) begin
            n_errors++; $display("FAIL nosync_count: got %0d want 1", got_data.size());
        end else if (got_data[0] !== 128'h0007_0006_0005_0004_0003_0002_0001_ABCD) begin
            n_errors++; $display("FAIL nosync_word: got %h want 000700060005000400030002 0001ABCD", got_data[0]);
        end
    endtask

    task automatic test_backpressure();
        // Ready low for 7 edges after valid rises: no loss.
        reset_dut();
        for (int p = 0; p < int'(FW * 8); p++) begin
            stacked_axis_ready = !(p >= 8 && p <= 14);
            send_px(1'b1, 16'(p), p == 0);
            if (p == 14) begin
                n_checks++;
                if (stacked_axis_valid !== 1'b1 || stacked_axis_data !== mk(16'd0)) begin
                    n_errors++; $display("FAIL bp_hold: got %b/%h want 1/%h", stacked_axis_valid, stacked_axis_data, mk(16'd0));
                end
            end
        end
        idle(4);
        n_checks++;
        if (overflow_out !== 1'b0) begin
            n_errors++; $display("FAIL bp7_overflow: got %b want 0", overflow_out);
        end
        n_checks++;
        if (got_data.size() != int'(FW)) begin
            n_errors++; $display("FAIL bp7_count: got %0d want %0d", got_data.size(), FW);
        end else begin
            for (int k = 0; k < int'(FW); k++) begin
                n_checks++;
                if (got_data[k] !== mk(16'(8 * k)) || got_last[k] !== (k == int'(FW) - 1)) begin
                    n_errors++; $display("FAIL bp7_word%0d: got %h/%b want %h", k, got_data[k], got_last[k], mk(16'(8 * k)));
                end
            end
        end

        // Ready low for 8 edges: second word dropped, held word survives.
        reset_dut();
        for (int p = 0; p < 16; p++) begin
            stacked_axis_ready = !(p >= 8);
            send_px(1'b1, 16'(p), p == 0);
        end
        n_checks++;
        if (overflow_out !== 1'b1 || stacked_axis_valid !== 1'b1 || stacked_axis_data !== mk(16'd0)) begin
            n_errors++; $display("FAIL bp8_drop: got ovf %b valid %b data %h want 1 1 %h", overflow_out, stacked_axis_valid, stacked_axis_data, mk(16'd0));
        end
        stacked_axis_ready = 1'b1;
        for (int p = 16; p < int'(FW * 8); p++) send_px(1'b1, 16'(p), 1'b0);
        for (int p = 0; p < 8; p++) send_px(1'b1, 16'(100 + p), p == 0);
        idle(4);
        n_checks++;
        if (got_data.size() != 2) begin
            n_errors++; $display("FAIL bp8_count: got %0d want 2", got_data.size());
        end else if (got_data[0] !== mk(16'd0) || got_data[1] !== mk(16'd100) || got_last[1] !== 1'b0) begin
            n_errors++; $display("FAIL bp8_words: got %h %h want %h %h", got_data[0], got_data[1], mk(16'd0), mk(16'd100));
        end
        n_checks++;
        if ({overflow_out, sync_error_out} !== 2'b10) begin
            n_errors++; $display("FAIL bp8_flags: got %b want 10", {overflow_out, sync_error_out});
        end
    endtask

    task automatic test_sync_error();
        logic [127:0] exp_w[6];
        reset_dut();
        exp_w[0] = mk(16'd0);
        exp_w[1] = mk(16'd8);
        exp_w[2] = mk(16'd1000);
        exp_w[3] = mk(16'd1008);
        exp_w[4] = mk(16'd1016);
        exp_w[5] = mk(16'd1024);
        for (int p = 0; p < 20; p++) send_px(1'b1, 16'(p), p == 0);
        for (int p = 0; p < int'(FW * 8); p++) send_px(1'b1, 16'(1000 + p), p == 0);
        idle(4);
        n_checks++;
        if (sync_error_out !== 1'b1 || overflow_out !== 1'b0) begin
            n_errors++; $display("FAIL syncerr_flags: got sync %b ovf %b want 1 0", sync_error_out, overflow_out);
        end
        n_checks++;
        if (got_data.size() != 6) begin
            n_errors++; $display("FAIL syncerr_count: got %0d want 6", got_data.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (got_data[k] !== exp_w[k] || got_last[k] !== (k == 5)) begin
                    n_errors++; $display("FAIL syncerr_word%0d: got %h/%b want %h/%b", k, got_data[k], got_last[k], exp_w[k], k == 5);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int low_run;
        int n_last;
        logic [15:0] base;
        reset_dut();
        low_run = 0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < int'(FW * 8); p++) begin
                if (low_run >= 7) stacked_axis_ready = 1'b1;
                else stacked_axis_ready = ($urandom_range(0, 2) != 0);
                low_run = stacked_axis_ready ? 0 : low_run + 1;
                send_px(1'b1, 16'(200 * f + p), p == 0);
            end
        end
        stacked_axis_ready = 1'b1;
        idle(6);
        n_checks++;
        if (got_data.size() != int'(2 * FW)) begin
            n_errors++; $display("FAIL b2b_count: got %0d want %0d", got_data.size(), 2 * FW);
        end else begin
            n_last = 0;
            for (int k = 0; k < int'(2 * FW); k++) begin
                base = 16'(200 * (k / int'(FW)) + 8 * (k % int'(FW)));
                if (got_last[k] === 1'b1) n_last++;
                n_checks++;
                if (got_data[k] !== mk(base) || got_last[k] !== ((k % int'(FW)) == int'(FW) - 1)) begin
                    n_errors++; $display("FAIL b2b_word%0d: got %h/%b want %h", k, got_data[k], got_last[k], mk(base));
                end
            end
            n_checks++;
            if (n_last != 2) begin
                n_errors++; $display("FAIL b2b_tlast_count: got %0d want 2", n_last);
            end
        end
        n_checks++;
        if ({overflow_out, sync_error_out} !== 2'b00) begin
            n_errors++; $display("FAIL b2b_flags: got %b want 00", {overflow_out, sync_error_out});
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        stacked_axis_ready = 1'b0;
        for (int p = 0; p < 10; p++) send_px(1'b1, 16'(p), p == 0);
        n_checks++;
        if (stacked_axis_valid !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_pre_valid: got %b want 1", stacked_axis_valid);
        end
        rst_in = 1'b1;
        send_px(1'b1, 16'd50, 1'b0);
        n_checks++;
        if (stacked_axis_valid !== 1'b0 || stacked_axis_data !== 128'h0 || stacked_axis_tlast !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_clear: got valid %b data %h tlast %b want 0 0 0", stacked_axis_valid, stacked_axis_data, stacked_axis_tlast);
        end
        rst_in = 1'b0;
        stacked_axis_ready = 1'b1;
        got_data.delete();
        got_last.delete();
        for (int p = 0; p < 8; p++) send_px(1'b1, 16'(60 + p), 1'b0);
        idle(3);
        n_checks++;
        if (got_data.size() != 0) begin
            n_errors++; $display("FAIL rstmid_nosync: got %0d words want 0", got_data.size());
        end
        for (int p = 0; p < 8; p++) send_px(1'b1, 16'(300 + p), p == 0);
        idle(3);
        n_checks++;
        if (got_data.size() != 1) begin
            n_errors++; $display("FAIL rstmid_count: got %0d want 1", got_data.size());
        end else if (got_data[0] !== mk(16'd300) || got_last[0] !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_word: got %h/%b want %h/0", got_data[0], got_last[0], mk(16'd300));
        end
        n_checks++;
        if ({overflow_out, sync_error_out} !== 2'b00) begin
            n_errors++; $display("FAIL rstmid_flags: got %b want 00", {overflow_out, sync_error_out});
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_no_sync();
        test_backpressure();
        test_sync_error();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
